// File: rtl/auth_uart_rx.sv
// 8N1 UART receiver feeding a G/S command FSM that gates the motor-drive enable.
// Latency: rx_rdy one cycle after the mid-stop sample; pwr_up one cycle after rx_rdy.
// No backpressure: rx_data is overwritten by every good frame, strobes are single-cycle.
module auth_uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    localparam logic [11:0] HALF_BIT = 12'(BAUD_DIV / 2);
    localparam logic [11:0] FULL_BIT = 12'(BAUD_DIV - 1);
    localparam logic [7:0]  CMD_GO   = 8'h47;
    localparam logic [7:0]  CMD_STOP = 8'h53;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

    rx_state_t   rx_state, rx_state_nx;
    auth_state_t auth, auth_nx;

    logic        rx_s1, rx_s2, rx_prev;
    logic [1:0]  sync_vld;
    logic        fall;
    logic [11:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        load_half, load_full, shift_en, good_stop, bad_stop;

    // Synchronizer plus edge history; rx_prev only becomes 1 once the line has
    // really been seen high, so a line held low through reset cannot fake a start.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            sync_vld <= 2'b00;
            rx_prev  <= 1'b0;
        end else begin
            rx_s1    <= RX;
            rx_s2    <= rx_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            rx_prev  <= sync_vld[1] & rx_s2;
        end
    end

    assign fall = rx_prev & ~rx_s2;

    // Receiver state register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) rx_state <= IDLE;
        else     rx_state <= rx_state_nx;
    end

    // Receiver next state and datapath controls; samples are taken when cnt hits 0.
    always_comb begin
        rx_state_nx = rx_state;
        load_half   = 1'b0;
        load_full   = 1'b0;
        shift_en    = 1'b0;
        good_stop   = 1'b0;
        bad_stop    = 1'b0;
        case (rx_state)
            IDLE: begin
                if (fall) begin
                    rx_state_nx = START;
                    load_half   = 1'b1;
                end
            end
            START: begin
                if (cnt == 12'd0) begin
                    if (rx_s2) begin
                        rx_state_nx = IDLE;
                    end else begin
                        rx_state_nx = DATA;
                        load_full   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (cnt == 12'd0) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == 3'd7) rx_state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == 12'd0) begin
                    rx_state_nx = IDLE;
                    good_stop   = rx_s2;
                    bad_stop    = ~rx_s2;
                end
            end
            default: rx_state_nx = IDLE;
        endcase
    end

    // Baud counter, bit counter, shift register and the registered strobes.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt     <= 12'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (load_half)         cnt <= HALF_BIT;
            else if (load_full)    cnt <= FULL_BIT;
            else if (cnt != 12'd0) cnt <= cnt - 12'd1;

            if (load_half)     bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

            if (shift_en)  shreg   <= {rx_s2, shreg[7:1]};
            if (good_stop) rx_data <= shreg;
            rx_rdy  <= good_stop;
            frm_err <= bad_stop;
        end
    end

    // Authorization state and registered enable, updated together.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            auth   <= OFF;
            pwr_up <= 1'b0;
        end else begin
            auth   <= auth_nx;
            pwr_up <= (auth_nx != OFF);
        end
    end

    // Command decode; rider_off in PWR2 wins over a simultaneous 'G'.
    always_comb begin
        auth_nx = auth;
        case (auth)
            OFF:  if (rx_rdy && rx_data == CMD_GO) auth_nx = PWR1;
            PWR1: if (rx_rdy && rx_data == CMD_STOP) auth_nx = rider_off ? OFF : PWR2;
            PWR2: begin
                if (rider_off)                         auth_nx = OFF;
                else if (rx_rdy && rx_data == CMD_GO)  auth_nx = PWR1;
            end
            default: auth_nx = OFF;
        endcase
    end

endmodule

// File: tb/tb_auth_uart_rx.sv
// Directed plus randomized bench for auth_uart_rx at 16 clocks per bit.
// Frames are driven bit-serially; a negedge monitor records strobes and data.
// Expected bytes and enable state come from a plain command-rule model.
module tb_auth_uart_rx;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       RST;
    logic       RX;
    logic       rider_off;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       pwr_up;

    int total = 0;
    int bad   = 0;

    int         n_rdy = 0;
    int         n_err = 0;
    logic [7:0] data_q[$];
    logic       pwr_at, pwr_after, rdy_d = 1'b0;

    auth_uart_rx #(.BAUD_DIV(BIT)) dut (
        .clk(clk), .RST(RST), .RX(RX), .rider_off(rider_off),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .frm_err(frm_err), .pwr_up(pwr_up)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rdy_d) pwr_after = pwr_up;
        rdy_d = rx_rdy;
        if (rx_rdy) begin
            n_rdy++;
            data_q.push_back(rx_data);
            pwr_at = pwr_up;
        end
        if (frm_err) n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the first nclk clocks of a frame (start, 8 data LSB first, stop).
    task automatic send(input logic [7:0] b, input logic stop, input int nclk);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int c = 0; c < nclk; c++) begin
            RX = fr[c / BIT];
            tick(1);
        end
    endtask

    // Command rules: 0=OFF 1=PWR1 2=PWR2.
    function automatic int auth_step(input int st, input bit vld, input logic [7:0] b, input bit ro);
        if (st == 2 && ro) return 0;
        if (!vld) return st;
        if (st == 0 && b == 8'h47) return 1;
        if (st == 1 && b == 8'h53) return ro ? 0 : 2;
        if (st == 2 && b == 8'h47) return 1;
        return st;
    endfunction

    initial begin
        int         st;
        int         exp_rdy;
        int         exp_err;
        logic [7:0] exp_data;
        logic [7:0] b;
        logic [7:0] got;
        bit         ro;
        logic       stop;

        RST = 1'b1; RX = 1'b1; rider_off = 1'b0;
        tick(3);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_rdy", 32'(rx_rdy), 32'h0);
        chk("reset_frm_err", 32'(frm_err), 32'h0);
        chk("reset_pwr_up", 32'(pwr_up), 32'h0);
        RST = 1'b0;
        tick(5);
        st = 0; exp_rdy = 0; exp_err = 0; exp_data = 8'h00;

        // 'G' with a clean stop bit turns power on one cycle after rx_rdy.
        send(8'h47, 1'b1, 10 * BIT); tick(20);
        exp_rdy++; exp_data = 8'h47; st = auth_step(st, 1, 8'h47, 0);
        chk("g_rdy_count", 32'(n_rdy), 32'(exp_rdy));
        chk("g_rx_data", 32'(rx_data), 32'(exp_data));
        chk("g_pwr_at_rdy", 32'(pwr_at), 32'h0);
        chk("g_pwr_after", 32'(pwr_after), 32'h1);
        chk("g_no_err", 32'(n_err), 32'(exp_err));
        got = data_q.pop_front();

        // 'S' with a rider present goes to PWR2, then rider_off drops power.
        send(8'h53, 1'b1, 10 * BIT); tick(20);
        exp_rdy++; exp_data = 8'h53; st = auth_step(st, 1, 8'h53, 0);
        chk("s_rider_rdy", 32'(n_rdy), 32'(exp_rdy));
        chk("s_rider_pwr", 32'(pwr_up), 32'(st != 0));
        got = data_q.pop_front();
        rider_off = 1'b1;
        chk("pwr2_before_edge", 32'(pwr_up), 32'h1);
        tick(1);
        st = auth_step(st, 0, 8'h00, 1);
        chk("pwr2_rider_off", 32'(pwr_up), 32'(st != 0));

        // Back to PWR1, then 'S' with no rider drops power straight away.
        rider_off = 1'b0;
        send(8'h47, 1'b1, 10 * BIT); tick(20);
        exp_rdy++; exp_data = 8'h47; st = auth_step(st, 1, 8'h47, 0);
        got = data_q.pop_front();
        rider_off = 1'b1;
        send(8'h53, 1'b1, 10 * BIT); tick(20);
        exp_rdy++; exp_data = 8'h53; st = auth_step(st, 1, 8'h53, 1);
        got = data_q.pop_front();
        chk("s_off_pwr_at_rdy", 32'(pwr_at), 32'h1);
        chk("s_off_pwr_after", 32'(pwr_after), 32'h0);
        rider_off = 1'b0;

        // 'G' with a low stop bit: framing error only, nothing else moves.
        send(8'h47, 1'b0, 10 * BIT); RX = 1'b1; tick(20);
        exp_err++;
        chk("ferr_count", 32'(n_err), 32'(exp_err));
        chk("ferr_no_rdy", 32'(n_rdy), 32'(exp_rdy));
        chk("ferr_rx_data", 32'(rx_data), 32'(exp_data));
        chk("ferr_pwr", 32'(pwr_up), 32'(st != 0));

        // Short low glitch is a false start.
        RX = 1'b0; tick(4); RX = 1'b1; tick(3 * BIT);
        chk("glitch_rdy", 32'(n_rdy), 32'(exp_rdy));
        chk("glitch_err", 32'(n_err), 32'(exp_err));

        // Back-to-back frames with no idle gap.
        send(8'hA5, 1'b1, 10 * BIT);
        send(8'h5A, 1'b1, 10 * BIT); tick(20);
        exp_rdy += 2; exp_data = 8'h5A;
        chk("b2b_count", 32'(n_rdy), 32'(exp_rdy));
        got = data_q.pop_front(); chk("b2b_first", 32'(got), 32'hA5);
        got = data_q.pop_front(); chk("b2b_second", 32'(got), 32'h5A);
        chk("b2b_pwr", 32'(pwr_up), 32'(st != 0));

        // Random command stream against the rule model.
        for (int i = 0; i < 16; i++) begin
            ro = bit'($urandom_range(0, 1));
            rider_off = ro;
            tick(2);
            st = auth_step(st, 0, 8'h00, ro);
            case ($urandom_range(0, 3))
                0: b = 8'h47;
                1: b = 8'h53;
                default: b = 8'($urandom_range(0, 255));
            endcase
            stop = ($urandom_range(0, 4) != 0);
            send(b, stop, 10 * BIT); RX = 1'b1; tick(20);
            if (stop) begin
                exp_rdy++; exp_data = b; st = auth_step(st, 1, b, ro);
                got = data_q.pop_front();
                chk("rand_byte", 32'(got), 32'(b));
            end else begin
                exp_err++;
            end
            chk("rand_rdy_count", 32'(n_rdy), 32'(exp_rdy));
            chk("rand_err_count", 32'(n_err), 32'(exp_err));
            chk("rand_rx_data", 32'(rx_data), 32'(exp_data));
            chk("rand_pwr", 32'(pwr_up), 32'(st != 0));
        end

        // Reset in the middle of bit 3 while powered; the line is low at that point.
        rider_off = 1'b0;
        send(8'h47, 1'b1, 10 * BIT); tick(20);
        exp_rdy++; st = 1;
        got = data_q.pop_front();
        chk("pre_reset_pwr", 32'(pwr_up), 32'h1);
        send(8'h47, 1'b1, 4 * BIT + BIT / 2);
        RST = 1'b1; #1;
        chk("midrst_rx_data", 32'(rx_data), 32'h00);
        chk("midrst_pwr", 32'(pwr_up), 32'h0);
        chk("midrst_rdy", 32'(rx_rdy), 32'h0);
        chk("midrst_err", 32'(frm_err), 32'h0);
        tick(3);
        RST = 1'b0;
        tick(3 * BIT);
        chk("post_rst_low_rdy", 32'(n_rdy), 32'(exp_rdy));
        chk("post_rst_low_err", 32'(n_err), 32'(exp_err));
        RX = 1'b1; tick(5);
        send(8'h47, 1'b1, 10 * BIT); tick(20);
        exp_rdy++;
        chk("after_rst_rdy", 32'(n_rdy), 32'(exp_rdy));
        chk("after_rst_data", 32'(rx_data), 32'h47);
        chk("after_rst_pwr", 32'(pwr_up), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/auth_uart_rx.md
AUTH_UART_RX -- requirements
Module: auth_uart_rx

Interface
- REQ-001 The block SHALL have parameter BAUD_DIV, default 2604, meaning clocks per bit (50 MHz / 19200 baud); legal range 16..4095.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
- REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
- REQ-004 The block SHALL have port RX, input, 1 bit: asynchronous serial line, 8N1, LSB first, idles high.
- REQ-005 The block SHALL have port rider_off, input, 1 bit: high when no rider load is present; synchronous to clk.
- REQ-006 The block SHALL have port rx_data, output, 8 bits: last correctly framed byte.
- REQ-007 The block SHALL have port rx_rdy, output, 1 bit: one-cycle strobe marking a new valid rx_data.
- REQ-008 The block SHALL have port frm_err, output, 1 bit: one-cycle strobe marking a byte whose stop bit sampled low.
- REQ-009 The block SHALL have port pwr_up, output, 1 bit: motor-drive enable.

Function (receiver)
- REQ-010 RX SHALL pass through a 2-flop synchronizer, preset to 1; the receiver acts only on the synchronized value.
- REQ-011 Receiver states SHALL be IDLE, START, DATA and STOP.
- REQ-012 IDLE -> START SHALL occur on a synchronized 1->0 edge; the baud counter loads BAUD_DIV/2 (integer division).
- REQ-013 In START, when the counter expires: a sample of 1 SHALL be treated as a false start (return to IDLE, no strobe); a sample of 0 SHALL move to DATA.
- REQ-014 In DATA, 8 bits SHALL be sampled, one every BAUD_DIV clocks, LSB first into a shift register; a 3-bit bit counter selects STOP after bit 7.
- REQ-015 STOP SHALL sample BAUD_DIV clocks after bit 7. If 1: rx_data loads the byte and rx_rdy = 1 for exactly the next cycle. If 0: frm_err = 1 for exactly one cycle and rx_data is unchanged.
- REQ-016 After the stop sample the receiver SHALL return to IDLE and accept a new start edge on the next cycle; back-to-back frames SHALL be received without loss.
- REQ-017 rx_data SHALL hold its value until the next valid frame; there is no clear handshake, and overrun silently overwrites.

Function (authorization FSM)
- REQ-018 Auth states SHALL be OFF, PWR1 and PWR2; pwr_up = 1 in PWR1 and PWR2, else 0, registered.
- REQ-019 OFF -> PWR1 SHALL occur on a valid byte 8'h47 ('G').
- REQ-020 PWR1 SHALL go to OFF on valid 8'h53 ('S') with rider_off = 1, or to PWR2 on valid 'S' with rider_off = 0.
- REQ-021 PWR2 SHALL go to OFF when rider_off = 1 (any cycle), or back to PWR1 on valid 'G' with rider_off = 0; rider_off = 1 has priority if both occur.
- REQ-022 Commands SHALL be acted on in the cycle rx_rdy is high, so pwr_up changes one clock after rx_rdy; framing-errored bytes and all other byte values SHALL be ignored.
- REQ-023 'G' in PWR1 and 'S' in OFF SHALL cause no change.

Reset
- REQ-024 RST high SHALL immediately force: receiver IDLE, synchronizer = 1, counters 0, rx_data = 8'h00, rx_rdy = 0, frm_err = 0, auth OFF, pwr_up = 0.
- REQ-025 RST mid-frame SHALL abort the frame with no strobe; after release, reception SHALL require a fresh 1->0 edge (a line held low SHALL not start a frame).

Verification (BAUD_DIV = 16)
- REQ-026 Send 8'h47 with a clean stop bit -> rx_rdy pulses once, rx_data = 8'h47, pwr_up = 1 one cycle later.
- REQ-027 From PWR1, send 8'h53 with rider_off = 0 -> pwr_up stays 1 (PWR2); then raise rider_off -> pwr_up = 0 next cycle.
- REQ-028 From PWR1, send 8'h53 with rider_off = 1 -> pwr_up = 0 one cycle after rx_rdy.
- REQ-029 Send 8'h47 with the stop bit driven 0 -> frm_err pulses once, no rx_rdy, rx_data and pwr_up unchanged.
- REQ-030 A 4-clock low glitch on RX -> false start, no strobes; back-to-back 8'hA5, 8'h5A -> two rx_rdy pulses with the correct data, state unchanged.
- REQ-031 Assert RST during bit 3 of a frame -> all outputs reset at once, no strobe; the next clean 'G' is received normally.
